lab3_seq_bls: RTL and testbench

LAB3_SEQ_BLS -- requirements
Module: lab3_seq_bls

---
 rtl/lab3_seq_bls.sv | 117 +++++++++++
 tb/tb_lab3_seq_bls.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lab3_seq_bls.sv
// Sequential add/subtract unit: one 4-bit carry-lookahead group per clock,
// LSB group first, with the group chain bit registered between cycles.
module lab3_seq_bls #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / 4;
   localparam int CW = (NG > 1) ? $clog2(NG) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] x_r, y_r, acc, acc_next;
   logic             mode_r, chain;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [3:0]       xg, yg, yi, p, g, sum;
   logic [4:0]       c;

   assign last = (cnt == CW'(NG - 1));
   assign busy = (state == BUSY);
   assign done = (state == DONE);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = BUSY;
         BUSY:    if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Subtraction runs as X + ~Y + ~Bin, so both modes share one adder group.
   always_comb begin
      xg = '0;
      yg = '0;
      for (int k = 0; k < NG; k++) begin
         if (cnt == CW'(k)) begin
            xg = x_r[4*k +: 4];
            yg = y_r[4*k +: 4];
         end
      end
      yi = mode_r ? yg : ~yg;
      p  = xg ^ yi;
      g  = xg & yi;
      c[0] = chain;
      c[1] = g[0] | (p[0] & chain);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & chain);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & chain);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & chain);
      sum = p ^ c[3:0];
      acc_next = acc;
      for (int k = 0; k < NG; k++) begin
         if (cnt == CW'(k)) acc_next[4*k +: 4] = sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         x_r    <= '0;
         y_r    <= '0;
         acc    <= '0;
         mode_r <= 1'b0;
         chain  <= 1'b0;
         Diff   <= '0;
         Bout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         state <= state_next;
         unique case (state)
            IDLE: begin
               if (start) begin
                  x_r    <= X;
                  y_r    <= Y;
                  mode_r <= mode;
                  chain  <= mode ? Bin : ~Bin;
                  cnt    <= '0;
                  acc    <= '0;
               end
            end
            BUSY: begin
               acc   <= acc_next;
               chain <= c[4];
               cnt   <= cnt + 1'b1;
               // Results are published only on the final group, so they hold between operations.
               if (last) begin
                  Diff <= acc_next;
                  Bout <= mode_r ? c[4] : ~c[4];
                  ovf  <= c[3] ^ c[4];
                  zero <= (acc_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lab3_seq_bls.sv
// Directed bench for lab3_seq_bls: a 16-bit instance for the main vectors and a
// 4-bit instance for the single-group case.
module tb_lab3_seq_bls;

   logic        clk = 1'b0;
   logic        rst_n, start, mode, Bin;
   logic [15:0] x, y, diff;
   logic        busy, done, bout, ovf, zero;
   logic        start4, mode4, bin4;
   logic [3:0]  x4, y4, diff4;
   logic        busy4, done4, bout4, ovf4, zero4;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   lab3_seq_bls #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .X(x), .Y(y), .Bin(Bin),
      .busy(busy), .done(done), .Diff(diff), .Bout(bout), .ovf(ovf), .zero(zero)
   );

   lab3_seq_bls #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .X(x4), .Y(y4), .Bin(bin4),
      .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4), .ovf(ovf4), .zero(zero4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Operands are scrambled right after the accepting edge to show they are latched.
   task automatic applyStimulus(input logic m, input logic [15:0] a, input logic [15:0] b,
                                input logic bi);
      @(negedge clk);
      mode = m; x = a; y = b; Bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = ~m; x = 16'($urandom); y = 16'($urandom); Bin = ~bi;
   endtask

   task automatic applyStimulus4(input logic m, input logic [3:0] a, input logic [3:0] b,
                                 input logic bi);
      @(negedge clk);
      mode4 = m; x4 = a; y4 = b; bin4 = bi; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; mode4 = ~m; x4 = ~a; y4 = ~b; bin4 = ~bi;
   endtask

   task automatic runOp(input string tag, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic bi, input logic [15:0] ediff,
                        input logic ebout, input logic eovf, input logic ezero);
      int n = 0;
      applyStimulus(m, a, b, bi);
      while (busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checkOutput({tag, " busy cycles"}, 32'(n), 32'd4);
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " diff"}, 32'(diff), 32'(ediff));
      checkOutput({tag, " bout"}, 32'(bout), 32'(ebout));
      checkOutput({tag, " ovf"}, 32'(ovf), 32'(eovf));
      checkOutput({tag, " zero"}, 32'(zero), 32'(ezero));
      @(negedge clk);
      checkOutput({tag, " done drop"}, 32'(done), 32'd0);
   endtask

   task automatic runOp4(input string tag, input logic m, input logic [3:0] a,
                         input logic [3:0] b, input logic bi, input logic [3:0] ediff,
                         input logic ebout, input logic eovf, input logic ezero);
      int n = 0;
      applyStimulus4(m, a, b, bi);
      while (busy4 === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checkOutput({tag, " busy cycles"}, 32'(n), 32'd1);
      checkOutput({tag, " done"}, 32'(done4), 32'd1);
      checkOutput({tag, " diff"}, 32'(diff4), 32'(ediff));
      checkOutput({tag, " bout"}, 32'(bout4), 32'(ebout));
      checkOutput({tag, " ovf"}, 32'(ovf4), 32'(eovf));
      checkOutput({tag, " zero"}, 32'(zero4), 32'(ezero));
      @(negedge clk);
      checkOutput({tag, " done drop"}, 32'(done4), 32'd0);
   endtask

   initial begin
      int          n, ndone;
      logic [15:0] seen;

      rst_n = 1'b0; start = 1'b0; mode = 1'b0; Bin = 1'b0; x = '0; y = '0;
      start4 = 1'b0; mode4 = 1'b0; bin4 = 1'b0; x4 = '0; y4 = '0;

      // No clock edge has occurred yet, so these values come from the async reset alone.
      #1;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset diff", 32'(diff), 32'd0);
      checkOutput("reset bout", 32'(bout), 32'd0);
      checkOutput("reset ovf", 32'(ovf), 32'd0);
      checkOutput("reset zero", 32'(zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      runOp("sub 1234-0234", 1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      runOp("sub 0000-0001", 1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      runOp("sub 8000-0001", 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      runOp("sub 1000-0FFF-1", 1'b0, 16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      runOp("sub 0005-0005-1", 1'b0, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      runOp("add FFFF+0001", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      runOp("add 7FFF+0001", 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      runOp("add 1234+4321+1", 1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("hold diff", 32'(diff), 32'h5556);

      // A start pulse in the second busy cycle must not restart or alter the operation.
      applyStimulus(1'b0, 16'h0050, 16'h0020, 1'b0);
      @(negedge clk);
      start = 1'b1; mode = 1'b1; x = 16'hFFFF; y = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) begin
            ndone++;
            seen = diff;
         end
         @(negedge clk);
      end
      checkOutput("busy start done count", 32'(ndone), 32'd1);
      checkOutput("busy start diff", 32'(seen), 32'h0030);

      runOp("add 8001+8000", 1'b1, 16'h8001, 16'h8000, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);

      // Abort in the second busy cycle; outputs must clear at once and no done may follow.
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort diff", 32'(diff), 32'd0);
      checkOutput("abort bout", 32'(bout), 32'd0);
      checkOutput("abort ovf", 32'(ovf), 32'd0);
      checkOutput("abort zero", 32'(zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) ndone++;
         @(negedge clk);
      end
      checkOutput("abort done count", 32'(ndone), 32'd0);
      checkOutput("abort diff held", 32'(diff), 32'd0);
      runOp("post-abort add", 1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

      // With start held high, consecutive done pulses are NG+2 = 6 cycles apart.
      @(negedge clk);
      mode = 1'b0; x = 16'h1234; y = 16'h0234; Bin = 1'b0; start = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      checkOutput("b2b first done", 32'(done), 32'd1);
      n = 0;
      @(negedge clk);
      n++;
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("b2b period", 32'(n), 32'd6);
      checkOutput("b2b diff", 32'(diff), 32'h1000);
      repeat (2) @(negedge clk);
      checkOutput("b2b idle busy", 32'(busy), 32'd0);

      runOp4("w4 sub 3-5", 1'b0, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
      runOp4("w4 add 7+1", 1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
